exec_alu_flags: RTL and testbench
=================================

// Module: exec_alu_flags
// PURPOSE
// Execute stage of the multi-phase ARM-subset core: a 32-bit ARM data-processing ALU
// (16 opcodes, NZCV flags), the CPSR flag register with per-flag write enables, and a
// free-running pipeline register capturing the ALU result for the writeback phase.
// Fed by the register file (Rn) and the barrel shifter (operand 2 + shifter carry).
// The CPSR C bit is also used internally as carry-in and exported to the shifter.
// PARAMETERS
// DATAW        32  datapath width; only 32 is supported
// FLAGS_START  28  CPSR bit index of V; C=29, Z=30, N=31
// PORTS
// clk            in   1   rising-edge clock
// reset          in   1   synchronous, active-high reset
// opcode         in   4   ARM data-processing opcode (instr[24:21])
// rn             in   32  first operand (Rn)
// shifter        in   32  second operand (shifter output)
// shifter_carry  in   1   shifter carry-out
// flag_we        in   4   per-flag CPSR write enable, {N,Z,C,V} = bits [3:0]
// alu_out        out  32  combinational ALU result
// flags_out      out  4   combinational result flags {N,Z,C,V}
// alu_out_q      out  32  alu_out registered one cycle
// cpsr           out  32  CPSR; only bits 31:28 are writable, all other bits read 0
// BEHAVIOUR
// - Opcodes (Cin = cpsr[29]):
//   0 AND rn&sh | 1 EOR rn^sh | 2 SUB rn-sh | 3 RSB sh-rn | 4 ADD rn+sh | 5 ADC rn+sh+Cin
//   6 SBC rn-sh-!Cin | 7 RSC sh-rn-!Cin | 8 TST rn&sh | 9 TEQ rn^sh | A CMP rn-sh
//   B CMN rn+sh | C ORR rn|sh | D MOV sh | E BIC rn&~sh | F MVN ~sh
// - Test ops (8-B) still drive their result on alu_out; writeback gating is external.
// - Arithmetic done in 33 bits; subtraction a-b-!c computed as a+~b+c.
// - N = alu_out[31]; Z = (alu_out == 0).
// - C: arithmetic ops = bit 32 of the 33-bit sum (subtracts: 1 = no borrow, ARM
//   convention); logical ops (0,1,8,9,C,D,E,F) = shifter_carry.
// - V: arithmetic ops = signed overflow (operands same sign, result sign differs,
//   using effective operands after inversion); logical ops = current cpsr[28].
// - alu_out and flags_out are purely combinational from inputs and cpsr; zero latency.
// - CPSR: on rising clk, if reset -> cpsr[31:28] = 0; else each flag bit i loads
//   flags_out[i] when flag_we[i]=1, otherwise holds. Partial enables update only the
//   selected bits. New flags are visible on cpsr (and as Cin) the cycle after the edge.
// - alu_out_q: on rising clk, reset -> 0; else alu_out_q <= alu_out every cycle (no enable).
// - Reset has priority over flag_we; outputs after reset: cpsr=0, alu_out_q=0.
// - Reset mid-operation discards any pending flag write for that edge.
// TESTING
// - ADD rn=0xFFFFFFFF sh=1, flag_we=F -> alu_out=0, flags N0 Z1 C1 V0; cpsr=0x60000000 next cycle.
// - SUB rn=5 sh=7 -> 0xFFFFFFFE, N1 Z0 C0 V0; CMP rn=7 sh=5 -> C1 (no borrow), Z0.
// - ADD rn=0x7FFFFFFF sh=1 -> 0x80000000, N1 V1 C0; ADC with cpsr C=1, rn=1 sh=1 -> 3.
// - MOV sh=0 shifter_carry=1, flag_we=0b1110 with cpsr V=1 -> Z1 C1, V stays 1.
// - flag_we=0 with any op -> cpsr unchanged; alu_out_q equals prior-cycle alu_out.
// - Assert reset with flag_we=F -> cpsr=0, alu_out_q=0 after the edge; release resumes.

Source files
------------

// File: rtl/exec_alu_flags.sv
// Execute stage: 32-bit ARM data-processing ALU with NZCV flags, CPSR flag register
// with per-flag write enables, and a free-running result register for writeback.
module exec_alu_flags #(
    parameter int DATAW       = 32,
    parameter int FLAGS_START = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [DATAW-1:0] rn,
    input  logic [DATAW-1:0] shifter,
    input  logic             shifter_carry,
    input  logic [3:0]       flag_we,
    output logic [DATAW-1:0] alu_out,
    output logic [3:0]       flags_out,
    output logic [DATAW-1:0] alu_out_q,
    output logic [DATAW-1:0] cpsr
);

    // Flags held as {N,Z,C,V}; bit 1 is the carry used as Cin.
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [DATAW-1:0] op_a_s;
    logic [DATAW-1:0] op_b_s;
    logic             cin_s;
    logic             arith_s;
    logic [DATAW-1:0] logic_res_s;
    logic [DATAW:0]   sum_s;
    logic             ovf_s;

    // Operand selection: subtracts become a + ~b + c so one adder serves all eight.
    always_comb begin
        op_a_s      = rn;
        op_b_s      = shifter;
        cin_s       = 1'b0;
        arith_s     = 1'b0;
        logic_res_s = {DATAW{1'b0}};
        case (opcode)
            4'h0, 4'h8: logic_res_s = rn & shifter;
            4'h1, 4'h9: logic_res_s = rn ^ shifter;
            4'hC:       logic_res_s = rn | shifter;
            4'hD:       logic_res_s = shifter;
            4'hE:       logic_res_s = rn & ~shifter;
            4'hF:       logic_res_s = ~shifter;
            4'h2, 4'hA: begin
                arith_s = 1'b1;
                op_b_s  = ~shifter;
                cin_s   = 1'b1;
            end
            4'h3: begin
                arith_s = 1'b1;
                op_a_s  = shifter;
                op_b_s  = ~rn;
                cin_s   = 1'b1;
            end
            4'h4, 4'hB: arith_s = 1'b1;
            4'h5: begin
                arith_s = 1'b1;
                cin_s   = flags_q[1];
            end
            4'h6: begin
                arith_s = 1'b1;
                op_b_s  = ~shifter;
                cin_s   = flags_q[1];
            end
            4'h7: begin
                arith_s = 1'b1;
                op_a_s  = shifter;
                op_b_s  = ~rn;
                cin_s   = flags_q[1];
            end
            default: logic_res_s = {DATAW{1'b0}};
        endcase
    end

    // 33-bit adder and signed-overflow detection on the effective operands.
    always_comb begin
        sum_s = {1'b0, op_a_s} + {1'b0, op_b_s} + {{DATAW{1'b0}}, cin_s};
        ovf_s = (op_a_s[DATAW-1] == op_b_s[DATAW-1]) &&
                (sum_s[DATAW-1] != op_a_s[DATAW-1]);
    end

    // Result and flag generation; logical ops take C from the shifter and keep V.
    always_comb begin
        flags_out = 4'd0;
        if (arith_s) begin
            alu_out      = sum_s[DATAW-1:0];
            flags_out[1] = sum_s[DATAW];
            flags_out[0] = ovf_s;
        end else begin
            alu_out      = logic_res_s;
            flags_out[1] = shifter_carry;
            flags_out[0] = flags_q[0];
        end
        flags_out[3] = alu_out[DATAW-1];
        flags_out[2] = (alu_out == {DATAW{1'b0}});
    end

    // Per-flag write enable merge.
    always_comb begin
        flags_d = (flags_out & flag_we) | (flags_q & ~flag_we);
    end

    // CPSR flags and writeback pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= 4'd0;
            alu_out_q <= {DATAW{1'b0}};
        end else begin
            flags_q   <= flags_d;
            alu_out_q <= alu_out;
        end
    end

    // Only the flag field of the CPSR is implemented; everything else reads 0.
    always_comb begin
        cpsr                       = {DATAW{1'b0}};
        cpsr[FLAGS_START +: 4]     = flags_q;
    end

endmodule

// File: tb/tb_exec_alu_flags.sv
// Self-checking bench for exec_alu_flags: reference model plus a scoreboard queue
// holding the registered results expected after each clock edge.
module tb_exec_alu_flags;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic [31:0] rn;
    logic [31:0] shifter;
    logic        shifter_carry;
    logic [3:0]  flag_we;
    logic [31:0] alu_out;
    logic [3:0]  flags_out;
    logic [31:0] alu_out_q;
    logic [31:0] cpsr;

    typedef struct packed {
        logic [31:0] alu_q;
        logic [31:0] cpsr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [3:0]  model_flags;
    logic [31:0] obs_alu;
    logic [3:0]  obs_flags;

    exec_alu_flags dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .rn            (rn),
        .shifter       (shifter),
        .shifter_carry (shifter_carry),
        .flag_we       (flag_we),
        .alu_out       (alu_out),
        .flags_out     (flags_out),
        .alu_out_q     (alu_out_q),
        .cpsr          (cpsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Arithmetic modelled with wide integers: true unsigned and signed results.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic sc,
                                  input logic [3:0] cp,
                                  output logic [31:0] res, output logic [3:0] fl);
        longint u;
        longint s;
        logic   is_sub;
        logic   is_arith;
        logic   c;
        logic   v;
        logic   cin;
        cin      = cp[1];
        is_sub   = 1'b0;
        is_arith = 1'b1;
        u        = 0;
        s        = 0;
        res      = 32'd0;
        case (op)
            4'h2, 4'hA: begin
                is_sub = 1'b1;
                u = longint'(a) - longint'(b);
                s = longint'($signed(a)) - longint'($signed(b));
            end
            4'h3: begin
                is_sub = 1'b1;
                u = longint'(b) - longint'(a);
                s = longint'($signed(b)) - longint'($signed(a));
            end
            4'h4, 4'hB: begin
                u = longint'(a) + longint'(b);
                s = longint'($signed(a)) + longint'($signed(b));
            end
            4'h5: begin
                u = longint'(a) + longint'(b) + longint'(cin);
                s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
            end
            4'h6: begin
                is_sub = 1'b1;
                u = longint'(a) - longint'(b) - longint'(!cin);
                s = longint'($signed(a)) - longint'($signed(b)) - longint'(!cin);
            end
            4'h7: begin
                is_sub = 1'b1;
                u = longint'(b) - longint'(a) - longint'(!cin);
                s = longint'($signed(b)) - longint'($signed(a)) - longint'(!cin);
            end
            4'h0, 4'h8: begin is_arith = 1'b0; res = a & b;  end
            4'h1, 4'h9: begin is_arith = 1'b0; res = a ^ b;  end
            4'hC:       begin is_arith = 1'b0; res = a | b;  end
            4'hD:       begin is_arith = 1'b0; res = b;      end
            4'hE:       begin is_arith = 1'b0; res = a & ~b; end
            default:    begin is_arith = 1'b0; res = ~b;     end
        endcase
        if (is_arith) begin
            res = u[31:0];
            c   = is_sub ? (u >= 0) : (u >= 64'sd4294967296);
            v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            c = sc;
            v = cp[0];
        end
        fl = {res[31], (res == 32'd0), c, v};
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_alu_q"}, alu_out_q, e.alu_q);
            check_eq({tag, "_cpsr"}, cpsr, e.cpsr);
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sc, input logic [3:0] we);
        logic [31:0] res;
        logic [3:0]  fl;
        logic [3:0]  nxt;
        exp_t        e;
        @(negedge clk);
        reset         = 1'b0;
        opcode        = op;
        rn            = a;
        shifter       = b;
        shifter_carry = sc;
        flag_we       = we;
        #1;
        model(op, a, b, sc, model_flags, res, fl);
        obs_alu   = alu_out;
        obs_flags = flags_out;
        check_eq({tag, "_alu"}, alu_out, res);
        check_eq({tag, "_flags"}, {28'd0, flags_out}, {28'd0, fl});
        nxt         = (fl & we) | (model_flags & ~we);
        e.alu_q     = res;
        e.cpsr      = {nxt, 28'd0};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
        model_flags = nxt;
    endtask

    task automatic do_reset(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        reset         = 1'b1;
        opcode        = op;
        rn            = a;
        shifter       = b;
        shifter_carry = 1'b1;
        flag_we       = 4'hF;
        e.alu_q       = 32'd0;
        e.cpsr        = 32'd0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
        model_flags = 4'd0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        model_flags   = 4'd0;
        reset         = 1'b1;
        opcode        = 4'h4;
        rn            = 32'd0;
        shifter       = 32'd0;
        shifter_carry = 1'b0;
        flag_we       = 4'h0;

        do_reset("rst0", 4'h4, 32'h1234_5678, 32'h1);
        do_reset("rst1", 4'hF, 32'h0, 32'h0);

        do_op("add_wrap", 4'h4, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'hF);
        check_eq("add_wrap_const_cpsr", cpsr, 32'h6000_0000);
        do_op("adc", 4'h5, 32'h1, 32'h1, 1'b0, 4'hF);
        check_eq("adc_const_res", obs_alu, 32'h3);
        do_op("sub_neg", 4'h2, 32'h5, 32'h7, 1'b0, 4'hF);
        check_eq("sub_neg_const_res", obs_alu, 32'hFFFF_FFFE);
        check_eq("sub_neg_const_flags", {28'd0, obs_flags}, 32'h8);
        do_op("cmp", 4'hA, 32'h7, 32'h5, 1'b0, 4'hF);
        check_eq("cmp_const_cpsr", cpsr, 32'h2000_0000);
        do_op("add_ovf", 4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'hF);
        check_eq("add_ovf_const_flags", {28'd0, obs_flags}, 32'h9);
        do_op("mov_part", 4'hD, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b1110);
        check_eq("mov_part_const_cpsr", cpsr, 32'h7000_0000);
        do_op("hold", 4'h2, 32'h0, 32'h1, 1'b0, 4'h0);
        check_eq("hold_const_cpsr", cpsr, 32'h7000_0000);
        do_op("sbc_c1", 4'h6, 32'h0, 32'hFFFF_FFFF, 1'b0, 4'hF);
        do_op("rsc", 4'h7, 32'h10, 32'h8, 1'b0, 4'hF);
        do_op("rsb", 4'h3, 32'h8000_0000, 32'h0, 1'b0, 4'hF);

        for (int i = 0; i < 16; i++) begin
            do_op("opsweep", i[3:0], 32'hF0F0_1234, 32'h8765_0F0F, i[0], 4'hF);
        end

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) ra = 32'h8000_0000;
            if (i % 5 == 0) rb = 32'hFFFF_FFFF;
            if (i == 30) do_reset("rst_mid", 4'h4, 32'hFFFF_FFFF, 32'h1);
            do_op("rand", 4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
        end

        if (sb_q.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
